// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with valid/ready ports, any depth, selectable
// registered or first-word-fall-through read data, occupancy, almost flags and flush.
module fifo_flex #(
  parameter int DataWidth     = 8,
  parameter int Depth         = 16,
  parameter int Fwft          = 0,
  parameter int AlmostFullTh  = Depth - 2,
  parameter int AlmostEmptyTh = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  input  logic [DataWidth-1:0]         data_i,
  input  logic                         rready_i,
  output logic                         rvalid_o,
  output logic [DataWidth-1:0]         data_o,
  output logic [$clog2(Depth+1)-1:0]   level_o,
  output logic                         is_full_o,
  output logic                         is_empty_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = $clog2(Depth + 1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_wrPtr;
  logic [PtrW-1:0]      r_rdPtr;
  logic [LvlW-1:0]      r_level;
  logic [DataWidth-1:0] r_dataOut;

  logic            w_push;
  logic            w_pop;
  logic [PtrW-1:0] w_wrPtrNext;
  logic [PtrW-1:0] w_rdPtrNext;

  assign is_full_o      = (r_level == LvlW'(Depth));
  assign is_empty_o     = (r_level == '0);
  assign almost_full_o  = (r_level >= LvlW'(AlmostFullTh));
  assign almost_empty_o = (r_level <= LvlW'(AlmostEmptyTh));
  assign level_o        = r_level;

  // wready_o looks only at the current level, so a full FIFO refuses a write
  // even when a pop happens in the same cycle.
  assign wready_o = ~is_full_o & ~reset_i;
  assign rvalid_o = ~is_empty_o;
  assign w_push   = wvalid_i & wready_o;
  assign w_pop    = rready_i & rvalid_o;

  assign w_wrPtrNext = (r_wrPtr == PtrW'(Depth - 1)) ? '0 : r_wrPtr + PtrW'(1);
  assign w_rdPtrNext = (r_rdPtr == PtrW'(Depth - 1)) ? '0 : r_rdPtr + PtrW'(1);

  assign data_o = (Fwft != 0) ? r_mem[r_rdPtr] : r_dataOut;

  // Storage has no reset; a flushed push is dropped.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_level   <= '0;
      r_dataOut <= '0;
    end else if (flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_pop) begin
        r_rdPtr   <= w_rdPtrNext;
        r_dataOut <= r_mem[r_rdPtr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LvlW'(1);
        2'b01:   r_level <= r_level - LvlW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: Depth=5, one registered-output and one FWFT
// instance driven by the same stimulus.
module tb_fifo_flex;

  localparam int DataWidth = 8;
  localparam int Depth     = 5;
  localparam int LvlW      = $clog2(Depth + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic                 wValid;
  logic [DataWidth-1:0] wData;
  logic                 rReady;

  logic                 wReadyReg, rValidReg, fullReg, emptyReg, aFullReg, aEmptyReg;
  logic [DataWidth-1:0] dataReg;
  logic [LvlW-1:0]      levelReg;
  logic                 wReadyFw, rValidFw, fullFw, emptyFw, aFullFw, aEmptyFw;
  logic [DataWidth-1:0] dataFw;
  logic [LvlW-1:0]      levelFw;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  fifo_flex #(.DataWidth(DataWidth), .Depth(Depth), .Fwft(0),
              .AlmostFullTh(4), .AlmostEmptyTh(1)) dutReg (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .wvalid_i(wValid), .wready_o(wReadyReg), .data_i(wData),
    .rready_i(rReady), .rvalid_o(rValidReg), .data_o(dataReg),
    .level_o(levelReg), .is_full_o(fullReg), .is_empty_o(emptyReg),
    .almost_full_o(aFullReg), .almost_empty_o(aEmptyReg)
  );

  fifo_flex #(.DataWidth(DataWidth), .Depth(Depth), .Fwft(1),
              .AlmostFullTh(4), .AlmostEmptyTh(1)) dutFw (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .wvalid_i(wValid), .wready_o(wReadyFw), .data_i(wData),
    .rready_i(rReady), .rvalid_o(rValidFw), .data_o(dataFw),
    .level_o(levelFw), .is_full_o(fullFw), .is_empty_o(emptyFw),
    .almost_full_o(aFullFw), .almost_empty_o(aEmptyFw)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the edge, then idle.
  task automatic applyStimulus(input logic w, input logic [DataWidth-1:0] d,
                               input logic r, input logic f);
    wValid = w;
    wData  = d;
    rReady = r;
    flush  = f;
    @(posedge clk);
    #1;
    wValid = 1'b0;
    rReady = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    flush  = 1'b0;
    wValid = 1'b0;
    wData  = '0;
    rReady = 1'b0;
    #1;
    checkOutput("reset level", 32'(levelReg), 32'd0);
    checkOutput("reset empty", 32'(emptyReg), 32'd1);
    checkOutput("reset full", 32'(fullReg), 32'd0);
    checkOutput("reset wready", 32'(wReadyReg), 32'd0);
    checkOutput("reset rvalid", 32'(rValidReg), 32'd0);
    checkOutput("reset almost empty", 32'(aEmptyReg), 32'd1);
    checkOutput("reset almost full", 32'(aFullReg), 32'd0);
    checkOutput("reset data", 32'(dataReg), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("release wready", 32'(wReadyReg), 32'd1);

    // Read-mode comparison; also leaves both pointers at 1 for the wrap test.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("fwft data before pop", 32'(dataFw), 32'hA5);
    checkOutput("reg data before pop", 32'(dataReg), 32'h00);
    checkOutput("rvalid after push", 32'(rValidReg), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("reg data after pop", 32'(dataReg), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("reg data holds", 32'(dataReg), 32'hA5);
    checkOutput("empty after pop", 32'(emptyReg), 32'd1);

    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        checkOutput("fill level", 32'(levelReg), 32'(i + 1));
        checkOutput("fill almost full", 32'(aFullReg), 32'((i + 1) >= 4));
        checkOutput("fill almost empty", 32'(aEmptyReg), 32'((i + 1) <= 1));
      end
      checkOutput("full flag", 32'(fullReg), 32'd1);
      checkOutput("full wready", 32'(wReadyReg), 32'd0);
      for (int i = 0; i < 5; i++) begin
        checkOutput("drain fwft head", 32'(dataFw), 32'(8'h10 + i));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain reg data", 32'(dataReg), 32'(8'h10 + i));
        if (i == 0) checkOutput("wready after full pop", 32'(wReadyReg), 32'd1);
      end
      checkOutput("drained empty", 32'(emptyReg), 32'd1);
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(8'h20 + k), 1'b1, 1'b0);
      checkOutput("stream level", 32'(levelReg), 32'd3);
      checkOutput("stream data", 32'(dataReg), (k < 3) ? 32'(8'h30 + k) : 32'(8'h20 + k - 3));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("stream tail", 32'(dataReg), 32'(8'h27 + i));
    end

    // A full FIFO with both requests only pops; 0x99 must never appear.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    checkOutput("full push+pop level", 32'(levelReg), 32'd4);
    checkOutput("full push+pop data", 32'(dataReg), 32'h40);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("post full drain", 32'(dataReg), 32'(8'h41 + i));
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b1);
    checkOutput("flush level", 32'(levelReg), 32'd0);
    checkOutput("flush empty", 32'(emptyReg), 32'd1);
    checkOutput("flush data holds", 32'(dataReg), 32'h44);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("post flush fwft", 32'(dataFw), 32'h44);
    checkOutput("post flush level", 32'(levelReg), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post flush pop", 32'(dataReg), 32'h44);
    checkOutput("post flush empty", 32'(emptyReg), 32'd1);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    checkOutput("pre reset level", 32'(levelReg), 32'd4);
    wValid = 1'b1;
    wData  = 8'h77;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid reset level", 32'(levelReg), 32'd0);
    checkOutput("mid reset wready", 32'(wReadyReg), 32'd0);
    checkOutput("mid reset empty", 32'(emptyReg), 32'd1);
    checkOutput("mid reset data", 32'(dataReg), 32'd0);
    @(posedge clk);
    #1;
    wValid = 1'b0;
    reset  = 1'b0;
    #1;
    checkOutput("post reset level", 32'(levelReg), 32'd0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("post reset fwft", 32'(dataFw), 32'h55);
    checkOutput("post reset level one", 32'(levelFw), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post reset pop", 32'(dataReg), 32'h55);
    checkOutput("post reset empty", 32'(emptyFw), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
